// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit path: letter codes, arbiter
// state encoding and the WAIT_DONE watchdog limit (used when
// MORSE_ARB_TIMEOUT_EN is defined).
package morse_pkg;

    localparam logic [2:0] A_CODE = 3'b000;
    localparam logic [2:0] B_CODE = 3'b001;
    localparam logic [2:0] C_CODE = 3'b010;
    localparam logic [2:0] D_CODE = 3'b011;
    localparam logic [2:0] E_CODE = 3'b100;
    localparam logic [2:0] F_CODE = 3'b101;
    localparam logic [2:0] G_CODE = 3'b110;
    localparam logic [2:0] H_CODE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    localparam logic [3:0] WDOG_TICKS = 4'd15;

endpackage

// File: rtl/morse_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first set request bit
// starting at the pointer and wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] pos;

    // Scan upward from the pointer; the first hit wins
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                sel[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/morse_tx_arbiter.sv
// Round-robin arbiter and sequencer for the shared Morse LED sender.
// Grants one requester, pulses snd_go, waits for snd_done, then holds an
// inter-letter gap measured in half-second ticks.
// Optional: define MORSE_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog and the
// timeout_err output.
import morse_pkg::*;

module morse_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int GAP_TICKS = 3,
    parameter int IDW       = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              tick,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] letter,
    output logic [NREQ-1:0]   grant,
    output logic              snd_go,
    output logic [2:0]        snd_letter,
    input  logic              snd_done,
    output logic [IDW-1:0]    active_id,
    output logic              busy
`ifdef MORSE_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TICKS);

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [GW-1:0]   gap_cnt;
    logic            capture;
    logic            gap_load;
    logic [NREQ-1:0] pick_sel;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [2:0]      pick_letter;
    logic [IDW-1:0]  ptr_nxt;

`ifdef MORSE_ARB_TIMEOUT_EN
    logic [3:0]      wdog_cnt;
    logic            wdog_trip;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .sel  (pick_sel),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Letter slice of the selected requester and the wrapped next pointer
    always_comb begin
        pick_letter = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                pick_letter = letter[3*i +: 3];
            end
        end
        ptr_nxt = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and capture/load strobes
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        gap_load  = 1'b0;
`ifdef MORSE_ARB_TIMEOUT_EN
        wdog_trip = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    capture   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (snd_done) begin
                    if (GAP_TICKS == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        gap_load  = 1'b1;
                        state_nxt = S_GAP;
                    end
                end
`ifdef MORSE_ARB_TIMEOUT_EN
                else if (tick && (wdog_cnt == WDOG_TICKS - 4'd1)) begin
                    wdog_trip = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            S_GAP: begin
                if (tick && (gap_cnt == GW'(1))) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Captured letter, grant/go pulses, round-robin pointer and gap counter
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            grant      <= '0;
            snd_go     <= 1'b0;
            snd_letter <= '0;
            active_id  <= '0;
            rr_ptr     <= '0;
            gap_cnt    <= '0;
        end else begin
            grant  <= capture ? pick_sel : '0;
            snd_go <= (state == S_ISSUE);
            if (capture) begin
                snd_letter <= pick_letter;
                active_id  <= pick_idx;
                rr_ptr     <= ptr_nxt;
            end
            if (gap_load) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && tick) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

`ifdef MORSE_ARB_TIMEOUT_EN
    // Watchdog: counts ticks while waiting for the sender, flags an abort
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wdog_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wdog_trip;
            if (state != S_WAIT_DONE) begin
                wdog_cnt <= '0;
            end else if (tick) begin
                wdog_cnt <= wdog_cnt + 4'd1;
            end
        end
    end
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: doc/morse_tx_arbiter.md
Name: morse_tx_arbiter

Overview:
- Round-robin arbiter and sequencer for the single Morse LED sender.
- Up to NREQ requesters each submit a 3-bit letter code (A=000 … H=111).
- The block grants one requester at a time, issues a one-cycle start to the sender, waits for its completion pulse, then holds an inter-letter gap counted in half-second ticks.
- Sits between the letter sources (switch/key front-ends, message ROM) and the Morse sender FSM; consumes the shared half-second enable from modulo_counter.

Parameters:
- NREQ, 4, number of requesters (2..8)
- GAP_TICKS, 3, inter-letter gap length in tick pulses (0 = no gap)
- IDW, 2, width of requester index; must equal ceil(log2(NREQ))

Ports:
- Clock  in  1  system clock
- Resetn  in  1  synchronous active-low reset
- tick  in  1  half-second enable, one-cycle pulse
- req  in  NREQ  per-requester request level
- letter  in  3*NREQ  letter code; requester i owns bits [3i+2:3i]
- grant  out  NREQ  one-hot, one-cycle acknowledge of capture
- snd_go  out  1  one-cycle start pulse to the sender
- snd_letter  out  3  captured letter, stable from capture until the next capture
- snd_done  in  1  one-cycle pulse from the sender at the end of the letter
- active_id  out  IDW  index of the requester currently served
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, Clock; reset Resetn is synchronous and active-low.
- Reset values: grant=0, snd_go=0, snd_letter=0, active_id=0, busy=0, rr pointer=0, gap counter=0, state=IDLE.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - Same edge: capture letter slice into snd_letter, set active_id, pulse grant[sel] for one cycle, rr pointer <= (sel+1) mod NREQ, go to ISSUE.
- ISSUE: snd_go=1 for exactly this one cycle; go to WAIT_DONE.
- WAIT_DONE:
  - Stay until snd_done=1.
  - On snd_done, go to GAP, loading the gap counter with GAP_TICKS. If GAP_TICKS=0, go directly to IDLE.
- GAP:
  - Decrement the counter on each tick.
  - When a tick arrives with counter==1, go to IDLE.
- Latency: req asserted in IDLE → grant on the next edge → snd_go one cycle later.
- Requester handshake:
  - The requester must drop req the cycle after grant. Otherwise it is re-arbitrated as a new request in a later round.
  - Letter changes after grant are ignored.
- Simultaneous events:
  - snd_done and tick in the same WAIT_DONE cycle: the tick is not counted toward the gap.
  - req changes during non-IDLE states are ignored until IDLE.
- snd_done outside WAIT_DONE is ignored.
- Reset mid-operation returns to IDLE immediately; any in-flight letter is abandoned and no grant or snd_go is issued.

Optional Feature:
- Macro: MORSE_ARB_TIMEOUT_EN.
- When defined:
  - WAIT_DONE counts tick pulses in a 4-bit watchdog.
  - If 15 ticks pass without snd_done, the block aborts to IDLE, skips GAP, and raises output timeout_err for one cycle.
  - The rr pointer still advances as normal.
- When undefined: no watchdog and no timeout_err port; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package morse_pkg:
  - letter code constants A_CODE..H_CODE (3'b000..3'b111)
  - state encoding constants S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT_DONE=2'd2, S_GAP=2'd3
  - watchdog limit WDOG_TICKS=15
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req, rr pointer.
  - Outputs: one-hot select, index, any.
  - Keeps the FSM file focused on sequencing.

Test Plan:
- Reset: after reset, request req=0001 with letter0=3'b010 → grant=0001 one cycle later, snd_go one cycle after that, snd_letter=010, active_id=0.
- Round robin: req=1111 held continuously, snd_done returned 5 cycles after each snd_go, GAP_TICKS=0 → grant order 0001,0010,0100,1000,0001.
- Gap: GAP_TICKS=3, snd_done then ticks spaced 10 cycles apart → busy falls exactly on the edge after the 3rd tick; tick coincident with snd_done not counted (4 ticks needed).
- Stability: letter0 changes from 000 to 111 after grant → snd_letter remains 000 until the next capture.
- Reset mid-letter: Resetn=0 for one cycle in WAIT_DONE → all outputs 0, state IDLE, rr pointer 0; a later snd_done is ignored.
- Timeout (MORSE_ARB_TIMEOUT_EN defined): no snd_done for 15 ticks → timeout_err pulses once, busy=0 next cycle, next grant goes to the following requester.
